// File: rtl/i2s_receiver_if.sv
// I2S receiver bus: serial pins in, reconstructed stereo samples and status out.
interface i2s_receiver_if #(
  parameter int unsigned WORD_SIZE = 24
);
  logic                 sclk;
  logic                 lrclk;
  logic                 sd;
  logic [WORD_SIZE-1:0] left_data;
  logic [WORD_SIZE-1:0] right_data;
  logic                 frame_valid;
  logic                 locked;

  modport master (
    output sclk, lrclk, sd,
    input  left_data, right_data, frame_valid, locked
  );

  modport slave (
    input  sclk, lrclk, sd,
    output left_data, right_data, frame_valid, locked
  );
endinterface

// File: rtl/i2s_receiver.sv
// Standard-I2S receiver oversampling sclk/lrclk/sd in the clk domain; emits
// left/right pairs only once a complete left-then-right frame has been captured.
module i2s_receiver #(
  parameter int unsigned WORD_SIZE   = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           nReset,
  i2s_receiver_if.slave bus
);

  localparam int unsigned CW = $clog2(WORD_SIZE + 1);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_SYNC     = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync_q, lr_sync_q, sd_sync_q;
  logic                   sclk_dly_q;
  logic                   sclk_s, lr_s, sd_s, rise;

  logic [1:0]           state_q, state_d;
  logic                 lr_prev_q, lr_prev_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] shreg_q, shreg_d;
  logic [WORD_SIZE-1:0] left_hold_q, left_hold_d;
  logic                 left_held_q, left_held_d;
  logic [WORD_SIZE-1:0] left_data_q, left_data_d;
  logic [WORD_SIZE-1:0] right_data_q, right_data_d;
  logic                 fv_q, fv_d;
  logic [WORD_SIZE-1:0] word;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      sclk_dly_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], bus.lrclk};
      sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], bus.sd};
      sclk_dly_q  <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign lr_s   = lr_sync_q[SYNC_STAGES-1];
  assign sd_s   = sd_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_dly_q;

  always_comb begin
    state_d      = state_q;
    lr_prev_d    = lr_prev_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    left_hold_d  = left_hold_q;
    left_held_d  = left_held_q;
    left_data_d  = left_data_q;
    right_data_d = right_data_q;
    fv_d         = 1'b0;

    // Current word including this rise's bit; no position matches once cnt saturates.
    word = shreg_q;
    for (int unsigned i = 0; i < WORD_SIZE; i++) begin
      if (32'(cnt_q) + i == WORD_SIZE - 1) word[i] = sd_s;
    end

    if (rise) begin
      lr_prev_d = lr_s;
      if (lr_s != lr_prev_q) begin
        cnt_d   = '0;
        shreg_d = '0;
        case (state_q)
          ST_UNLOCKED: state_d = ST_SYNC;
          ST_SYNC:     state_d = ST_RUN;
          ST_RUN: begin
            if (lr_s) begin
              left_hold_d = word;
              left_held_d = 1'b1;
            end else if (left_held_q) begin
              left_data_d  = left_hold_q;
              right_data_d = word;
              fv_d         = 1'b1;
              left_held_d  = 1'b0;
            end
          end
          default:     state_d = ST_UNLOCKED;
        endcase
      end else begin
        shreg_d = word;
        if (cnt_q != CW'(WORD_SIZE)) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= ST_UNLOCKED;
      lr_prev_q    <= 1'b0;
      cnt_q        <= '0;
      shreg_q      <= '0;
      left_hold_q  <= '0;
      left_held_q  <= 1'b0;
      left_data_q  <= '0;
      right_data_q <= '0;
      fv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      lr_prev_q    <= lr_prev_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      left_hold_q  <= left_hold_d;
      left_held_q  <= left_held_d;
      left_data_q  <= left_data_d;
      right_data_q <= right_data_d;
      fv_q         <= fv_d;
    end
  end

  assign bus.left_data   = left_data_q;
  assign bus.right_data  = right_data_q;
  assign bus.frame_valid = fv_q;
  assign bus.locked      = (state_q != ST_UNLOCKED);

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: I2S source model, table of word formats, scoreboard of expected pairs.
module tb_i2s_receiver;
  localparam int unsigned WS = 24;

  logic clk = 1'b0;
  logic nReset;
  i2s_receiver_if #(.WORD_SIZE(WS)) bus ();

  i2s_receiver #(.WORD_SIZE(WS), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WS-1:0] l;
    logic [WS-1:0] r;
  } pair_t;

  typedef struct {
    int            n;
    int            half;
    logic [31:0]   l;
    logic [31:0]   r;
    logic [WS-1:0] exp_l;
    logic [WS-1:0] exp_r;
  } vec_t;

  pair_t sb_q[$];
  pair_t exp_p;
  vec_t  tbl[5];
  int    checks = 0;
  int    errors = 0;
  int    half   = 4;
  logic  fv_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WS-1:0] justify(input logic [63:0] w, input int n);
    logic [63:0] m;
    m = w & ((64'd1 << n) - 64'd1);
    if (n >= int'(WS)) return WS'(m >> (n - int'(WS)));
    return WS'(m << (int'(WS) - n));
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One slot: lrclk/sd change while sclk is low, optional lrclk glitch before the rise.
  task automatic send_bit(input logic lr, input logic b, input bit glitch);
    bus.lrclk = lr;
    bus.sd    = b;
    if (glitch) begin
      wait_clk(1);
      bus.lrclk = ~lr;
      wait_clk(1);
      bus.lrclk = lr;
      wait_clk(half - 2);
    end else begin
      wait_clk(half);
    end
    bus.sclk = 1'b1;
    wait_clk(half);
    bus.sclk = 1'b0;
  endtask

  // Slots first..last of an n-bit word; lrclk flips on the LSB slot (standard I2S).
  task automatic send_slots(input logic ch, input logic [63:0] w, input int n,
                            input int first, input int last, input bit glitch);
    for (int k = first; k <= last; k++)
      send_bit((k == n - 1) ? ~ch : ch, w[n-1-k], glitch);
  endtask

  task automatic push_exp(input logic [WS-1:0] el, input logic [WS-1:0] er);
    pair_t p;
    p.l = el;
    p.r = er;
    sb_q.push_back(p);
  endtask

  task automatic send_frame(input int n, input logic [63:0] l, input logic [63:0] r,
                            input bit push, input logic [WS-1:0] el, input logic [WS-1:0] er);
    send_slots(1'b0, l, n, 0, n - 1, 1'b0);
    if (push) push_exp(el, er);
    send_slots(1'b1, r, n, 0, n - 1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (bus.frame_valid) begin
      chk("frame_valid_width", 64'(fv_prev), 64'd0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_frame_valid: got pulse left %h right %h expected no pulse",
                 bus.left_data, bus.right_data);
      end else begin
        exp_p = sb_q.pop_front();
        chk("left_data", 64'(bus.left_data), 64'(exp_p.l));
        chk("right_data", 64'(bus.right_data), 64'(exp_p.r));
      end
    end
    fv_prev <= bus.frame_valid;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rl, rr;

    tbl[0] = '{24, 4, 32'h00FF_FFFF, 32'h0000_0000, 24'hFFFFFF, 24'h000000};
    tbl[1] = '{24, 4, 32'h0001_0101, 32'h0010_1010, 24'h010101, 24'h101010};
    tbl[2] = '{32, 4, 32'hA5A5_A5FF, 32'h8001_3C3C, 24'hA5A5A5, 24'h80013C};
    tbl[3] = '{16, 4, 32'h0000_7E81, 32'h0000_8001, 24'h7E8100, 24'h800100};
    tbl[4] = '{24, 2, 32'h00C3_5A96, 32'h0069_A53C, 24'hC35A96, 24'h69A53C};

    bus.sclk  = 1'b0;
    bus.lrclk = 1'b0;
    bus.sd    = 1'b0;
    nReset    = 1'b0;
    wait_clk(3);
    chk("reset_left", 64'(bus.left_data), 64'd0);
    chk("reset_right", 64'(bus.right_data), 64'd0);
    chk("reset_fv", 64'(bus.frame_valid), 64'd0);
    chk("reset_locked", 64'(bus.locked), 64'd0);
    nReset = 1'b1;
    wait_clk(3);
    chk("idle_unlocked", 64'(bus.locked), 64'd0);

    // Locking frame: its data is discarded.
    send_frame(24, 64'h123456, 64'h654321, 1'b0, '0, '0);
    chk("locked_after_sync", 64'(bus.locked), 64'd1);

    for (int i = 0; i < 5; i++) begin
      half = tbl[i].half;
      for (int j = 0; j < 2; j++)
        send_frame(tbl[i].n, 64'(tbl[i].l), 64'(tbl[i].r), 1'b1, tbl[i].exp_l, tbl[i].exp_r);
    end

    half = 4;
    send_slots(1'b0, 64'h3C55AA, 24, 0, 23, 1'b1);
    push_exp(24'h3C55AA, 24'hC3AA55);
    send_slots(1'b1, 64'hC3AA55, 24, 0, 23, 1'b1);
    wait_clk(10);

    half = 2;
    for (int i = 0; i < 100; i++) begin
      rl = $urandom;
      rr = $urandom;
      send_frame(24, 64'(rl), 64'(rr), 1'b1, justify(64'(rl), 24), justify(64'(rr), 24));
    end
    wait_clk(10);
    chk("drained_random", 64'(sb_q.size()), 64'd0);

    // Reset in the middle of a left word.
    half = 4;
    send_slots(1'b0, 64'hABCDEF, 24, 0, 11, 1'b0);
    @(negedge clk);
    #2 nReset = 1'b0;
    #1;
    chk("midreset_left", 64'(bus.left_data), 64'd0);
    chk("midreset_right", 64'(bus.right_data), 64'd0);
    chk("midreset_fv", 64'(bus.frame_valid), 64'd0);
    chk("midreset_locked", 64'(bus.locked), 64'd0);
    wait_clk(2);
    bus.lrclk = 1'b0;
    bus.sd    = 1'b0;
    nReset    = 1'b1;
    wait_clk(3);
    send_frame(24, 64'hCAFE01, 64'h0BEEF2, 1'b0, '0, '0);
    chk("relocked", 64'(bus.locked), 64'd1);
    send_frame(24, 64'h13579B, 64'h2468AC, 1'b1, 24'h13579B, 24'h2468AC);
    wait_clk(10);

    // Source starts mid-left-word; lock timing measured from the LSB-slot rise.
    nReset = 1'b0;
    wait_clk(2);
    bus.lrclk = 1'b0;
    nReset    = 1'b1;
    wait_clk(3);
    send_slots(1'b0, 64'h5A5A5A, 24, 14, 22, 1'b0);
    wait_clk(6);
    chk("midleft_unlocked", 64'(bus.locked), 64'd0);
    bus.lrclk = 1'b1;
    bus.sd    = 1'b0;
    wait_clk(half);
    bus.sclk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("lock_latency_edge2", 64'(bus.locked), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lock_latency_edge3", 64'(bus.locked), 64'd1);
    wait_clk(2);
    bus.sclk = 1'b0;
    send_slots(1'b1, 64'h777777, 24, 0, 23, 1'b0);
    send_frame(24, 64'h0F0F0F, 64'hF0F0F0, 1'b1, 24'h0F0F0F, 24'hF0F0F0);
    wait_clk(10);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
